// File: rtl/fxp_div_pkg.sv
// rtl/fxp_div_pkg.sv - shared FSM state type and sizing helpers for the sequential divider
package fxp_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ZERO
   } div_state_t;

   // One restoring step per raw quotient bit; the dividend carries FRAC extra zero bits.
   function automatic int calc_iter(input int width, input int frac);
      return width + frac;
   endfunction

   function automatic int calc_cnt_w(input int width, input int frac);
      return $clog2(width + frac);
   endfunction

endpackage

// File: rtl/fxp_div_step.sv
// rtl/fxp_div_step.sv - one combinational restoring-division step
module fxp_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] d_ext;
   logic [WIDTH+1:0] trial;

   // rem_in stays below d, so the shifted value never reaches the sign bit of trial.
   always_comb begin
      shifted = {rem_in, bit_in};
      d_ext   = (WIDTH+2)'(d);
      trial   = shifted - d_ext;
      q_bit   = ~trial[WIDTH+1];
      rem_out = q_bit ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);
   end

endmodule

// File: rtl/fxp_seq_divider.sv
// rtl/fxp_seq_divider.sv - multi-cycle unsigned fixed-point restoring divider with saturation
module fxp_seq_divider
   import fxp_div_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FRAC  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] d,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int ITER  = calc_iter(WIDTH, FRAC);
   localparam int CNT_W = calc_cnt_w(WIDTH, FRAC);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   prem;
   logic [ITER-1:0]  dvd;
   logic [ITER-1:0]  quot;
   logic [WIDTH-1:0] d_reg;

   logic [WIDTH:0]   prem_next;
   logic             q_bit;
   logic [ITER-1:0]  quot_next;
   logic             ovf_next;

   fxp_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in (prem),
      .bit_in (dvd[ITER-1]),
      .d      (d_reg),
      .rem_out(prem_next),
      .q_bit  (q_bit)
   );

   assign quot_next = ITER'({quot, q_bit});
   // Any raw quotient bit above the result width means the value is out of range.
   assign ovf_next  = |(quot_next >> WIDTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         prem        <= '0;
         dvd         <= '0;
         quot        <= '0;
         d_reg       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         q           <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd   <= ITER'(n) << FRAC;
                  d_reg <= d;
                  prem  <= '0;
                  quot  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= (d == '0) ? ZERO : CALC;
               end
            end
            CALC: begin
               dvd  <= dvd << 1;
               prem <= prem_next;
               quot <= quot_next;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(ITER-1)) begin
                  q           <= ovf_next ? '1 : WIDTH'(quot_next);
                  rem         <= prem_next[WIDTH-1:0];
                  overflow    <= ovf_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            ZERO: begin
               q           <= '1;
               rem         <= '0;
               overflow    <= 1'b0;
               div_by_zero <= 1'b1;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fxp_seq_divider.md
# fxp_seq_divider

Parametrised, multi-cycle, unsigned fixed-point restoring divider. It succeeds the 8-bit combinational Q4.4 divider and generalises it to any width and fraction split. It adds a start/busy/done handshake, a remainder output, divide-by-zero detection and overflow saturation. It sits in the arithmetic datapath wherever a quotient can tolerate WIDTH+FRAC cycles of latency in exchange for one subtractor.

## Interface
- WIDTH, 8: total operand/result bits. Must be ≥ 2.
- FRAC, 4: fraction bits of the unsigned Q(WIDTH-FRAC).FRAC format. Must satisfy 0 ≤ FRAC < WIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- n  in  WIDTH  dividend, Q format; captured on the accepted start.
- d  in  WIDTH  divisor, Q format; captured on the accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when results update.
- q  out  WIDTH  quotient, Q format; held until the next done.
- rem  out  WIDTH  integer remainder of (n·2^FRAC) mod d; held until the next done.
- div_by_zero  out  1  result flag, held with q.
- overflow  out  1  result flag, held with q.

## Operation
- Arithmetic: q = floor(n·2^FRAC / d), computed as a raw integer quotient of ITER = WIDTH+FRAC bits. The dividend is n zero-extended and shifted left by FRAC.
- Restoring step, applied once per cycle, MSB first:
  - shift the partial remainder (WIDTH+1 bits) left and bring in the next dividend bit;
  - trial-subtract d;
  - if the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
- Overflow: if any raw quotient bit above WIDTH-1 is set, q saturates to all ones and overflow=1. rem still reports the true remainder.
- Divide by zero: if d=0 at accept, no iteration runs. The result is q=all ones, rem=0, div_by_zero=1, overflow=0.
- FSM states:
  - IDLE: busy=0. On start, capture n and d, clear the partial remainder and counter, then go to CALC. If d=0, go to ZERO instead.
  - CALC: busy=1. Perform one step per cycle with the counter at 0..ITER-1. On the step with counter=ITER-1, register q/rem/flags, pulse done, and go to IDLE.
  - ZERO: busy=1 for one cycle. Register the divide-by-zero result, pulse done, and go to IDLE.
- start is ignored while busy=1; n and d may change freely during a division.
- Reset (at any time, including mid-division) aborts immediately:
  - state=IDLE;
  - busy, done, q, rem, div_by_zero and overflow all 0;
  - the counter and partial remainder are cleared.

## Timing
- An accepted start at edge E0 raises busy after E0.
- Normal division: done=1 and results are valid after edge E_ITER, so latency is ITER cycles (12 at the defaults). busy falls on the same edge.
- Divide by zero: done and results are valid after E1, so latency is 1 cycle.
- done lasts exactly one cycle. Outputs change only on edges where done rises, or on reset.
- Back-to-back operation: busy=0 during the done cycle, so a start in that cycle is accepted. Maximum throughput is one division per ITER cycles.

## Structure
- Package fxp_div_pkg holds:
  - the FSM state enum (IDLE, CALC, ZERO);
  - a function computing ITER and the counter width, $clog2(ITER).
- Sub-module fxp_div_step is combinational and WIDTH-parametrised:
  - inputs: partial remainder, incoming dividend bit, divisor;
  - outputs: next partial remainder, quotient bit.
- The top level holds the FSM, the counter, the operand/dividend shift register, the quotient shift register and the output registers.

## Test plan
All vectors use the defaults (WIDTH=8, FRAC=4, Q4.4) unless noted.
- n=0x80 (8), d=0xF0 (15) -> after 12 cycles: q=0x08, overflow=0, div_by_zero=0, one-cycle done.
- n=0x88 (8.5), d=0x20 (2) -> q=0x44 (4.25), rem=0. n=0x20, d=0x30 (2/3) -> q=0x0A, rem=0x20.
- n=0x40 (4), d=0x08 (0.5) -> quotient 8.0 fits, q=0x80, overflow=0. n=0x80 (8), d=0x08 (0.5) -> 16 exceeds the Q4.4 range, q=0xFF, overflow=1.
- d=0x00, n=0x50 -> done one cycle after accept, q=0xFF, rem=0, div_by_zero=1.
- Handshake sequence:
  - start pulsed mid-division -> ignored, results unchanged;
  - start held high through done -> a second division is accepted in the done cycle and completes 12 cycles later;
  - rst asserted at cycle 5 of a division -> all outputs 0 immediately and no done follows.
- WIDTH=16, FRAC=8, n=0x0100 (1), d=0x0300 (3) -> q=0x0055 after 24 cycles. Bench also checks 1000 random pairs against a reference model (q, rem and flags).
